// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller and the fetcher side that talks to it.
// Holds the bus widths, FSM state encoding and arbitration port identifiers.
package sram_controller_pkg;

    localparam int ADDR_SIZE = 15;
    localparam int DATA_SIZE = 8;
    localparam int WAIT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

endpackage

// File: rtl/sram_controller_if.sv
// Fetch port, data port and SRAM pin bundle between the controller and its neighbours.
// The slave modport is the controller's view; master is the requester/SRAM side.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic [ADDR_SIZE-1:0] fetch_addr;
    logic                 fetch_rd_en;
    logic [DATA_SIZE-1:0] fetch_d_out;
    logic                 fetch_ack;

    logic [ADDR_SIZE-1:0] data_addr;
    logic                 data_rd_en;
    logic                 data_wr_en;
    logic [DATA_SIZE-1:0] data_wdata;
    logic [DATA_SIZE-1:0] data_d_out;
    logic                 data_ack;

    logic [ADDR_SIZE-1:0] sram_addr;
    logic [DATA_SIZE-1:0] sram_dq_out;
    logic                 sram_dq_oe;
    logic [DATA_SIZE-1:0] sram_dq_in;
    logic                 sram_ce_n;
    logic                 sram_oe_n;
    logic                 sram_we_n;

    modport slave (
        input  fetch_addr, fetch_rd_en,
        output fetch_d_out, fetch_ack,
        input  data_addr, data_rd_en, data_wr_en, data_wdata,
        output data_d_out, data_ack,
        output sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_dq_in,
        output sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output fetch_addr, fetch_rd_en,
        input  fetch_d_out, fetch_ack,
        output data_addr, data_rd_en, data_wr_en, data_wdata,
        input  data_d_out, data_ack,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        output sram_dq_in,
        input  sram_ce_n, sram_oe_n, sram_we_n
    );

endinterface

// File: rtl/sram_controller.sv
// Round-robin arbiter between the fetch and data ports onto one asynchronous SRAM bank,
// with a fixed wait-state count per access and a one-cycle acknowledge on the granted port.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_controller_if.slave   bus
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_t               state;
    state_t               next_state;
    port_t                last_grant;
    port_t                sel_port;
    logic                 start;
    logic                 is_write;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0] wr_data;
    logic [DATA_SIZE-1:0] rd_data;

    logic fetch_req;
    logic data_req;
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
    logic fetch_ack;
    logic data_ack;

    assign fetch_req = bus.fetch_rd_en;
    assign data_req  = bus.data_rd_en | bus.data_wr_en;

    // last_grant doubles as the owner of the access in flight, so DONE uses it to route the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= PORT_DATA;
            is_write   <= 1'b0;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wr_data    <= '0;
            rd_data    <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                last_grant <= sel_port;
                wait_cnt   <= WAIT_LOAD;
                if (sel_port == PORT_FETCH) begin
                    addr_q   <= bus.fetch_addr;
                    is_write <= 1'b0;
                end else begin
                    addr_q   <= bus.data_addr;
                    is_write <= bus.data_wr_en;
                    wr_data  <= bus.data_wdata;
                end
            end else if (state == ACCESS) begin
                if (wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end else if (!is_write) begin
                    rd_data <= bus.sram_dq_in;
                end
            end
        end
    end

    // A data request with both read and write raised is serviced as a write.
    always_comb begin
        next_state = state;
        sel_port   = last_grant;
        start      = 1'b0;
        ce_n       = 1'b1;
        oe_n       = 1'b1;
        we_n       = 1'b1;
        dq_oe      = 1'b0;
        fetch_ack  = 1'b0;
        data_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    start      = 1'b1;
                    next_state = ACCESS;
                    if (fetch_req && data_req) begin
                        sel_port = (last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
                    end else begin
                        sel_port = fetch_req ? PORT_FETCH : PORT_DATA;
                    end
                end
            end
            ACCESS: begin
                ce_n = 1'b0;
                if (is_write) begin
                    dq_oe = 1'b1;
                    if (wait_cnt != WAIT_LOAD) begin
                        we_n = 1'b0;
                    end
                end else begin
                    oe_n = 1'b0;
                end
                if (wait_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                fetch_ack  = (last_grant == PORT_FETCH);
                data_ack   = (last_grant == PORT_DATA);
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = wr_data;
    assign bus.sram_dq_oe  = dq_oe;
    assign bus.sram_ce_n   = ce_n;
    assign bus.sram_oe_n   = oe_n;
    assign bus.sram_we_n   = we_n;
    assign bus.fetch_ack   = fetch_ack;
    assign bus.data_ack    = data_ack;
    assign bus.fetch_d_out = rd_data;
    assign bus.data_d_out  = rd_data;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: fetch/data reads and writes against a small SRAM model,
// tie arbitration, back-to-back fetches, mid-access reset and the read+write protocol error.
module tb_sram_controller;
    import sram_controller_pkg::*;

    logic clk;
    logic reset;
    logic preload;

    int checks;
    int failures;

    int                   lat;
    logic [DATA_SIZE-1:0] dout;
    int                   ce_cnt;
    int                   oe_cnt;
    int                   we_cnt;
    int                   dqoe_cnt;
    int                   first_we;
    int                   other_ack;
    logic [ADDR_SIZE-1:0] addr_seen;

    logic [DATA_SIZE-1:0] mem [0:(1 << ADDR_SIZE) - 1];

    sram_controller_if bus ();

    sram_controller #(.WAIT_STATES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: write commits while ce_n/we_n are low, read is combinational.
    always @(posedge clk) begin
        if (preload) begin
            mem[15'h1003] <= 8'hA5;
            mem[15'h2010] <= 8'hEE;
            mem[15'h0055] <= 8'h11;
        end else if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            mem[bus.sram_addr] <= bus.sram_dq_out;
        end
    end

    assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr] : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic f_rd, input logic [ADDR_SIZE-1:0] f_addr,
                                 input logic d_rd, input logic d_wr,
                                 input logic [ADDR_SIZE-1:0] d_addr,
                                 input logic [DATA_SIZE-1:0] wdata);
        bus.fetch_rd_en = f_rd;
        bus.fetch_addr  = f_addr;
        bus.data_rd_en  = d_rd;
        bus.data_wr_en  = d_wr;
        bus.data_addr   = d_addr;
        bus.data_wdata  = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Steps cycle by cycle until the wanted port acks (bounded), tallying strobes on the way.
    task automatic wait_ack(input bit want_data);
        lat       = -1;
        dout      = '0;
        ce_cnt    = 0;
        oe_cnt    = 0;
        we_cnt    = 0;
        dqoe_cnt  = 0;
        first_we  = 0;
        other_ack = 0;
        addr_seen = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) addr_seen = bus.sram_addr;
            if (!bus.sram_ce_n) ce_cnt++;
            if (!bus.sram_oe_n) oe_cnt++;
            if (bus.sram_dq_oe) dqoe_cnt++;
            if (!bus.sram_we_n) begin
                we_cnt++;
                if (first_we == 0) first_we = i;
            end
            if (want_data ? bus.fetch_ack : bus.data_ack) other_ack++;
            if (want_data ? bus.data_ack : bus.fetch_ack) begin
                lat  = i;
                dout = want_data ? bus.data_d_out : bus.fetch_d_out;
                break;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        preload  = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        preload = 1'b0;
        tick();

        $display("[TB] reset values");
        checkOutput("rst_fetch_ack", 32'(bus.fetch_ack), 32'd0);
        checkOutput("rst_data_ack", 32'(bus.data_ack), 32'd0);
        checkOutput("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        checkOutput("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
        checkOutput("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        checkOutput("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        checkOutput("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        checkOutput("rst_fetch_d_out", 32'(bus.fetch_d_out), 32'd0);
        checkOutput("rst_data_d_out", 32'(bus.data_d_out), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] fetch read 0x1003");
        applyStimulus(1'b1, 15'h1003, 1'b0, 1'b0, '0, '0);
        wait_ack(1'b0);
        checkOutput("fetch_lat", 32'(lat), 32'd4);
        checkOutput("fetch_dout", 32'(dout), 32'hA5);
        checkOutput("fetch_ce_cycles", 32'(ce_cnt), 32'd3);
        checkOutput("fetch_oe_cycles", 32'(oe_cnt), 32'd3);
        checkOutput("fetch_we_cycles", 32'(we_cnt), 32'd0);
        checkOutput("fetch_data_ack", 32'(other_ack), 32'd0);
        checkOutput("fetch_sram_addr", 32'(addr_seen), 32'h1003);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("fetch_ack_single", 32'(bus.fetch_ack), 32'd0);

        $display("[TB] data write 0x2010 <= 0x3C");
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 15'h2010, 8'h3C);
        wait_ack(1'b1);
        checkOutput("wr_lat", 32'(lat), 32'd4);
        checkOutput("wr_we_cycles", 32'(we_cnt), 32'd2);
        checkOutput("wr_first_we", 32'(first_we), 32'd2);
        checkOutput("wr_dqoe_cycles", 32'(dqoe_cnt), 32'd3);
        checkOutput("wr_oe_cycles", 32'(oe_cnt), 32'd0);
        checkOutput("wr_fetch_ack", 32'(other_ack), 32'd0);
        checkOutput("wr_sram_addr", 32'(addr_seen), 32'h2010);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("wr_ack_single", 32'(bus.data_ack), 32'd0);

        $display("[TB] data read-back 0x2010, address changed while pending");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 15'h2010, '0);
        tick();
        bus.data_addr = 15'h1003;
        wait_ack(1'b1);
        checkOutput("rd_lat", 32'(lat), 32'd3);
        checkOutput("rd_dout", 32'(dout), 32'h3C);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] tie after reset: fetch first, then data");
        reset = 1'b1;
        repeat (2) tick();
        checkOutput("rst2_fetch_d_out", 32'(bus.fetch_d_out), 32'd0);
        checkOutput("rst2_sram_addr", 32'(bus.sram_addr), 32'd0);
        reset = 1'b0;
        tick();
        applyStimulus(1'b1, 15'h1003, 1'b1, 1'b0, 15'h2010, '0);
        wait_ack(1'b0);
        checkOutput("tie1_fetch_lat", 32'(lat), 32'd4);
        checkOutput("tie1_fetch_dout", 32'(dout), 32'hA5);
        bus.fetch_rd_en = 1'b0;
        wait_ack(1'b1);
        checkOutput("tie1_data_lat", 32'(lat), 32'd5);
        checkOutput("tie1_data_dout", 32'(dout), 32'h3C);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] tie after a fetch: data first, then fetch");
        applyStimulus(1'b1, 15'h1003, 1'b0, 1'b0, '0, '0);
        wait_ack(1'b0);
        checkOutput("tie2_pre_lat", 32'(lat), 32'd4);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        applyStimulus(1'b1, 15'h1003, 1'b1, 1'b0, 15'h2010, '0);
        wait_ack(1'b1);
        checkOutput("tie2_data_lat", 32'(lat), 32'd4);
        checkOutput("tie2_data_dout", 32'(dout), 32'h3C);
        bus.data_rd_en = 1'b0;
        wait_ack(1'b0);
        checkOutput("tie2_fetch_lat", 32'(lat), 32'd5);
        checkOutput("tie2_fetch_dout", 32'(dout), 32'hA5);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] continuous fetch");
        applyStimulus(1'b1, 15'h1003, 1'b0, 1'b0, '0, '0);
        wait_ack(1'b0);
        checkOutput("cont_lat0", 32'(lat), 32'd4);
        wait_ack(1'b0);
        checkOutput("cont_lat1", 32'(lat), 32'd5);
        wait_ack(1'b0);
        checkOutput("cont_lat2", 32'(lat), 32'd5);
        checkOutput("cont_dout", 32'(dout), 32'hA5);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] reset in second ACCESS cycle");
        applyStimulus(1'b1, 15'h1003, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        checkOutput("mid_ce_active", 32'(bus.sram_ce_n), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("mid_ce_n", 32'(bus.sram_ce_n), 32'd1);
        checkOutput("mid_oe_n", 32'(bus.sram_oe_n), 32'd1);
        checkOutput("mid_we_n", 32'(bus.sram_we_n), 32'd1);
        checkOutput("mid_fetch_ack", 32'(bus.fetch_ack), 32'd0);
        reset = 1'b0;
        wait_ack(1'b0);
        checkOutput("mid_retry_lat", 32'(lat), 32'd4);
        checkOutput("mid_retry_dout", 32'(dout), 32'hA5);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("[TB] read and write raised together on the data port");
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 15'h0055, 8'h77);
        wait_ack(1'b1);
        checkOutput("rw_lat", 32'(lat), 32'd4);
        checkOutput("rw_we_cycles", 32'(we_cnt), 32'd2);
        checkOutput("rw_oe_cycles", 32'(oe_cnt), 32'd0);
        checkOutput("rw_fetch_ack", 32'(other_ack), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();
        checkOutput("rw_ack_single", 32'(bus.data_ack), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 15'h0055, '0);
        wait_ack(1'b1);
        checkOutput("rw_readback", 32'(dout), 32'h77);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Responder side of the fetcher memory port: it serves one instruction fetcher's read requests and the execution stage's data reads and writes on a single asynchronous 8-bit SRAM bank. It arbitrates between the two ports round-robin, drives SRAM strobes with a fixed number of wait states, and returns a one-cycle acknowledge with the read data. One instance sits per fetcher/SRAM half of the processor.

## Interface
- ADDR_SIZE, 15, SRAM address width: {channel[2:0], local address[11:0]}
- DATA_SIZE, 8, SRAM data width
- WAIT_STATES, 2, extra SRAM cycles per access beyond the first; legal range 1..15
- clk  in  1  clock; all activity on the positive edge
- reset  in  1  synchronous, active-high
- fetch_addr  in  ADDR_SIZE  fetcher read address
- fetch_rd_en  in  1  fetcher read request, level, held until ack
- fetch_d_out  out  DATA_SIZE  read data, valid while fetch_ack=1
- fetch_ack  out  1  one-cycle acknowledge of a fetch read
- data_addr  in  ADDR_SIZE  execution-stage address
- data_rd_en  in  1  data read request, level, held until ack
- data_wr_en  in  1  data write request, level, held until ack
- data_wdata  in  DATA_SIZE  write data
- data_d_out  out  DATA_SIZE  read data, valid while data_ack=1
- data_ack  out  1  one-cycle acknowledge of a data read or write
- sram_addr  out  ADDR_SIZE  SRAM address, registered
- sram_dq_out  out  DATA_SIZE  SRAM write data
- sram_dq_oe  out  1  drive enable for sram_dq_out
- sram_dq_in  in  DATA_SIZE  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is high, grant one port.
  - Latch its address, direction, and write data.
  - Load wait counter = WAIT_STATES and go to ACCESS.
- ACCESS:
  - ce_n=0.
  - Read: oe_n=0.
  - Write: dq_oe=1 on every ACCESS cycle; we_n=0 on every ACCESS cycle except the first.
  - The counter decrements each cycle. At counter 0, a read captures sram_dq_in into the read register, then the state goes to DONE.
- DONE:
  - Strobes inactive.
  - Pulse ack on the granted port only; the read register is presented on that port's d_out.
  - Always return to IDLE; no request is arbitrated in DONE.
- Arbitration: a `last_grant` register holds the port granted most recently. When both ports request in IDLE, the port that is not `last_grant` wins. Reset value is DATA, so fetch wins the first tie.
- Data port with data_rd_en and data_wr_en both high is a protocol error; it is treated as a write.
- Request inputs are sampled only in IDLE. A change of addr or wdata while a request is pending has no effect on the current access.
- fetch_d_out and data_d_out are both driven from the shared read register; only the ack qualifies them.

## Timing
- Reset values:
  - Outputs: fetch_ack=0, data_ack=0, ce_n=1, oe_n=1, we_n=1, dq_oe=0, sram_addr=0, d_out=0.
  - State IDLE, last_grant=DATA.
- Request high in IDLE at edge N:
  - ACCESS occupies cycles N+1 .. N+1+WAIT_STATES.
  - ack is high in cycle N+2+WAIT_STATES.
  - With WAIT_STATES=2: ack in cycle N+4.
- A request still high in the cycle after its ack is a new request. Back-to-back accesses from one port are spaced WAIT_STATES+3 cycles apart.
- Reset asserted mid-access: the next edge forces IDLE, all strobes inactive, no ack; the access is discarded.
- Requests arriving while ACCESS or DONE are held by the requester and serviced from the next IDLE.

## Structure
- Shared package holds:
  - state encoding constants IDLE/ACCESS/DONE;
  - port-select constants PORT_FETCH/PORT_DATA;
  - ADDR_SIZE and DATA_SIZE defaults, shared with the fetcher.
- Single module. The wait counter and arbiter stay inline; no sub-module is warranted.

## Test plan
- Reset, then fetch_rd_en=1 with fetch_addr=15'h1003 and SRAM model returning 8'hA5:
  - ce_n/oe_n low for 3 cycles;
  - fetch_ack high exactly 4 cycles after the request edge, with fetch_d_out=8'hA5;
  - data_ack stays 0.
- Data write, data_addr=15'h2010, data_wdata=8'h3C:
  - we_n low on ACCESS cycles 2–3 only, dq_oe high on all 3 ACCESS cycles;
  - data_ack pulses once;
  - a following read of 15'h2010 returns 8'h3C.
- fetch_rd_en and data_rd_en raised on the same edge after reset:
  - fetch is served first, then data;
  - repeating the tie alternates the grant order.
- fetch_rd_en held high continuously: one ack every 5 cycles (WAIT_STATES=2); each ack is a single cycle.
- reset asserted in the second ACCESS cycle: next cycle all strobes high, no ack; a re-issued request completes normally.
- data_rd_en and data_wr_en both high: a write occurs (we_n asserted) and a single data_ack is issued.
